// File: rtl/apsm_pkg.sv
// Shared APSM definitions: arbiter FSM encodings, rail IDs and the grant-priority rule.
package apsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_BLANK = 2'd3
    } apsm_state_e;

    localparam logic RAIL_5V    = 1'b0;
    localparam logic RAIL_OTHER = 1'b1;

    // An emergency-qualified rail beats the other; a tie with both requesting alternates.
    function automatic logic pick_rail(input logic req_5v, input logic req_other,
                                       input logic emerg_5v, input logic emerg_other,
                                       input logic last_grant);
        logic q_5v;
        logic q_other;
        q_5v    = req_5v & emerg_5v;
        q_other = req_other & emerg_other;
        if (q_5v != q_other) begin
            return q_other ? RAIL_OTHER : RAIL_5V;
        end else if (req_5v && req_other) begin
            return ~last_grant;
        end else begin
            return req_other ? RAIL_OTHER : RAIL_5V;
        end
    endfunction

endpackage

// File: rtl/apsm_phase_timer.sv
// Loadable down-counter timing one arbiter phase; done marks the last clock of the phase.
module apsm_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apsm_pulse_arbiter.sv
// Arbitrates two rail APSM requests onto one power stage with dead-time, fixed pulse and blanking,
// and tracks sustained contention to drive load_sharing_active back to the rail controllers.
module apsm_pulse_arbiter
    import apsm_pkg::*;
#(
    parameter int PULSE_CYCLES = 64,
    parameter int DEAD_CYCLES  = 8,
    parameter int BLANK_CYCLES = 16,
    parameter int LS_ENTER     = 4,
    parameter int LS_EXIT      = 8,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset_in,
    input  logic req_5v,
    input  logic req_other,
    input  logic emerg_5v,
    input  logic emerg_other,
    input  logic abort,
    output logic gate_5v,
    output logic gate_other,
    output logic grant_id,
    output logic busy,
    output logic load_sharing_active
);

    localparam int SH_W = $clog2(LS_ENTER + 1);
    localparam int SO_W = $clog2(LS_EXIT + 1);

    apsm_state_e     state_q, state_d;
    logic            grant_q, grant_d;
    logic            gate_5v_q, gate_5v_d;
    logic            gate_other_q, gate_other_d;
    logic            busy_q, busy_d;
    logic            ls_q, ls_d;
    logic [SH_W-1:0] share_q, share_d;
    logic [SO_W-1:0] solo_q, solo_d;

    logic             decision;
    logic             to_blank;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;

    apsm_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_in (reset_in),
        .load     (tmr_load),
        .value    (tmr_value),
        .done     (tmr_done)
    );

    assign decision = (state_q == ST_IDLE) && (req_5v || req_other) && !abort;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        to_blank  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (decision) begin
                    grant_d  = pick_rail(req_5v, req_other, emerg_5v, emerg_other, grant_q);
                    tmr_load = 1'b1;
                    if (DEAD_CYCLES == 0) begin
                        state_d   = ST_PULSE;
                        tmr_value = CNT_W'(PULSE_CYCLES);
                    end else begin
                        state_d   = ST_DEAD;
                        tmr_value = CNT_W'(DEAD_CYCLES);
                    end
                end
            end
            ST_DEAD: begin
                if (abort) begin
                    to_blank = 1'b1;
                end else if (tmr_done) begin
                    state_d   = ST_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(PULSE_CYCLES);
                end
            end
            ST_PULSE: begin
                to_blank = abort || tmr_done;
            end
            ST_BLANK: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A zero-length blanking window falls straight through to IDLE.
        if (to_blank) begin
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(BLANK_CYCLES);
            state_d   = (BLANK_CYCLES == 0) ? ST_IDLE : ST_BLANK;
        end
    end

    always_comb begin
        share_d = share_q;
        solo_d  = solo_q;
        ls_d    = ls_q;
        if (decision) begin
            if (req_5v && req_other) begin
                share_d = (share_q == SH_W'(LS_ENTER)) ? share_q : share_q + 1'b1;
                solo_d  = '0;
                if (share_d == SH_W'(LS_ENTER)) ls_d = 1'b1;
            end else begin
                solo_d  = (solo_q == SO_W'(LS_EXIT)) ? solo_q : solo_q + 1'b1;
                share_d = '0;
                if (solo_d == SO_W'(LS_EXIT)) ls_d = 1'b0;
            end
        end
    end

    // Gates follow the registered state one clock later, so abort is masked in directly.
    always_comb begin
        gate_5v_d    = (state_q == ST_PULSE) && !abort && (grant_q == RAIL_5V);
        gate_other_d = (state_q == ST_PULSE) && !abort && (grant_q == RAIL_OTHER);
        busy_d       = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            grant_q      <= RAIL_OTHER;
            gate_5v_q    <= 1'b0;
            gate_other_q <= 1'b0;
            busy_q       <= 1'b0;
            ls_q         <= 1'b0;
            share_q      <= '0;
            solo_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gate_5v_q    <= gate_5v_d;
            gate_other_q <= gate_other_d;
            busy_q       <= busy_d;
            ls_q         <= ls_d;
            share_q      <= share_d;
            solo_q       <= solo_d;
        end
    end

    assign gate_5v             = gate_5v_q;
    assign gate_other          = gate_other_q;
    assign grant_id            = grant_q;
    assign busy                = busy_q;
    assign load_sharing_active = ls_q;

endmodule

// File: tb/tb_apsm_pulse_arbiter.sv
// Scoreboard bench: a timestamp-based reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the arbiter.
module tb_apsm_pulse_arbiter;

    localparam int D = 8;
    localparam int P = 64;
    localparam int B = 16;
    localparam int LS_IN  = 4;
    localparam int LS_OUT = 8;

    logic clk;
    logic reset_in, req_5v, req_other, emerg_5v, emerg_other, abort;
    logic gate_5v, gate_other, grant_id, busy, load_sharing_active;

    apsm_pulse_arbiter dut (
        .clk                 (clk),
        .reset_in            (reset_in),
        .req_5v              (req_5v),
        .req_other           (req_other),
        .emerg_5v            (emerg_5v),
        .emerg_other         (emerg_other),
        .abort               (abort),
        .gate_5v             (gate_5v),
        .gate_other          (gate_other),
        .grant_id            (grant_id),
        .busy                (busy),
        .load_sharing_active (load_sharing_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {gate_5v, gate_other, busy, grant_id, load_sharing_active} after each edge.
    logic [4:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a pulse is a decision timestamp plus optional abort timestamp.
    int cyc    = 0;
    int t_dec  = 0;
    int e_ab   = 0;
    int end_e  = 0;
    int free_e = 0;
    bit act     = 0;
    bit ab_seen = 0;
    bit m_grant = 1;
    bit m_ls    = 0;
    int m_share = 0;
    int m_solo  = 0;
    int n_dec   = 0;

    task automatic model_step();
        bit g;
        bit bz;
        bit q5;
        bit qo;
        if (reset_in) begin
            act = 0; m_grant = 1; m_ls = 0; m_share = 0; m_solo = 0;
            free_e = cyc + 1;
            exp_q.push_back(5'b00010);
        end else begin
            if (act && !ab_seen && abort && cyc >= t_dec + 1 && cyc <= t_dec + D + P) begin
                ab_seen = 1; e_ab = cyc; end_e = cyc + B; free_e = end_e + 1;
            end
            if (cyc >= free_e && (req_5v || req_other) && !abort) begin
                q5 = req_5v & emerg_5v;
                qo = req_other & emerg_other;
                if (q5 != qo) m_grant = qo;
                else if (req_5v && req_other) m_grant = !m_grant;
                else m_grant = req_other;
                if (req_5v && req_other) begin
                    m_share = (m_share < LS_IN) ? m_share + 1 : m_share;
                    m_solo = 0;
                    if (m_share == LS_IN) m_ls = 1;
                end else begin
                    m_solo = (m_solo < LS_OUT) ? m_solo + 1 : m_solo;
                    m_share = 0;
                    if (m_solo == LS_OUT) m_ls = 0;
                end
                act = 1; ab_seen = 0; t_dec = cyc;
                end_e = cyc + D + P + B; free_e = end_e + 1;
                n_dec++;
            end
            g  = act && cyc >= t_dec + D + 1 && cyc <= t_dec + D + P && (!ab_seen || cyc < e_ab);
            bz = act && cyc >= t_dec + 1 && cyc <= end_e;
            exp_q.push_back({g && !m_grant, g && m_grant, bz, m_grant, m_ls});
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin : monitor
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(negedge clk);
            act_v = {gate_5v, gate_other, busy, grant_id, load_sharing_active};
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard_empty t=%0t got %b", $time, act_v);
            end else begin
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL outputs edge=%0d got %b want %b (g5,go,busy,grant,ls)",
                             cyc - 1, act_v, exp_v);
                end
            end
            n_cmp++;
            if ((gate_5v & gate_other) !== 1'b0) begin
                n_err++;
                $display("FAIL gate_overlap t=%0t got g5=%b go=%b want not both", $time, gate_5v, gate_other);
            end
        end
    end

    initial begin : stimulus
        int k;
        bit rst_done;
        int offs[4];
        offs[0] = D + 20; offs[1] = D + P; offs[2] = 3; offs[3] = D + 1;
        reset_in = 1; req_5v = 0; req_other = 0; emerg_5v = 0; emerg_other = 0; abort = 0;
        repeat (3) step();
        reset_in = 0;
        // Single request, then continuous contention.
        repeat (9) step();
        req_5v = 1;
        repeat (250) step();
        req_other = 1;
        repeat (450) step();
        // Emergency on the other rail wins every decision.
        emerg_other = 1;
        repeat (300) step();
        emerg_other = 0;
        // Only 5 V requests: sharing flag must drop at the 8th solo decision.
        req_other = 0;
        repeat (820) step();
        // Aborts at chosen phase offsets, including the last pulse clock.
        req_other = 1;
        k = 0;
        repeat (700) begin
            abort = act && !ab_seen && (cyc == t_dec + offs[k]);
            if (abort) k = (k + 1) % 4;
            step();
        end
        abort = 0;
        // Reset mid-pulse, then contention resumes.
        rst_done = 0;
        repeat (400) begin
            reset_in = !rst_done && act && (cyc == t_dec + D + 30);
            if (reset_in) rst_done = 1;
            step();
        end
        reset_in = 0;
        // Randomized traffic.
        repeat (2000) begin
            req_5v      = ($urandom_range(0, 3) != 0);
            req_other   = ($urandom_range(0, 2) == 0);
            emerg_5v    = ($urandom_range(0, 4) == 0);
            emerg_other = ($urandom_range(0, 4) == 0);
            abort       = ($urandom_range(0, 29) == 0);
            reset_in    = ($urandom_range(0, 499) == 0);
            step();
        end
        reset_in = 0; abort = 0; req_5v = 0; req_other = 0;
        repeat (3) step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apsm_pulse_arbiter.md
# apsm_pulse_arbiter

Consumer end of the per-rail APSM request interface. It takes the registered `APSM_request` and emergency flags from two rail controllers (5 V rail and the other rail) and arbitrates them onto one shared power stage. It generates dead-time-protected, fixed-width gate pulses and drives the `load_sharing_active` flag back to both controllers. It sits between the rail regulation blocks and the gate-driver pins.

## Interface
- `PULSE_CYCLES`, 64: gate on-time in clocks (≥1).
- `DEAD_CYCLES`, 8: gates-low interval before each pulse (0 allowed → state skipped).
- `BLANK_CYCLES`, 16: minimum gates-low interval after each pulse (0 allowed → state skipped).
- `LS_ENTER`, 4: consecutive contended decisions needed to assert load sharing.
- `LS_EXIT`, 8: consecutive uncontended decisions needed to deassert load sharing.
- `CNT_W`, 8: width of the phase timer; must hold max(PULSE, DEAD, BLANK).

Ports:
- `clk` in 1: single clock domain.
- `reset_in` in 1: synchronous, active-high reset.
- `req_5v` in 1: `APSM_request` from the 5 V controller; level.
- `req_other` in 1: `APSM_request` from the other-rail controller; level.
- `emerg_5v` in 1: `emergency_condition` of the 5 V rail.
- `emerg_other` in 1: `emergency_condition` of the other rail.
- `abort` in 1: stage fault or over-voltage clamp; terminates any pulse.
- `gate_5v` out 1: registered gate drive for the 5 V leg.
- `gate_other` out 1: registered gate drive for the other leg.
- `grant_id` out 1: rail of the current or last grant; 0 = 5 V, 1 = other.
- `busy` out 1: high whenever state ≠ IDLE.
- `load_sharing_active` out 1: registered; fed back to both controllers.

## Operation
- FSM states: IDLE → DEAD → PULSE → BLANK → IDLE. All outputs are registered.
- **Decision.** A decision occurs on any IDLE edge where `req_5v | req_other` is high and `abort` is low. On that edge:
  - latch `grant_id`;
  - load the timer with DEAD_CYCLES and go to DEAD;
  - if DEAD_CYCLES = 0, load PULSE_CYCLES and go directly to PULSE.
- **Grant priority:**
  1. A rail with both request and emergency high wins.
  2. If both or neither rail qualify under rule 1 and both request, use round-robin: grant the rail opposite to the last `grant_id`.
  3. If only one rail requests, grant that rail.
- **Reset value of `grant_id`** is 1, so the first contended decision goes to 5 V.
- **Phase timer.** Each phase lasts exactly its count in clocks. The timer loads N on entry and the phase exits on the edge where the timer equals 1.
- **PULSE.** Only the gate selected by `grant_id` is high. The pulse runs full length even if the request drops.
- **Abort.** `abort` high in DEAD or PULSE → both gates low on the next edge and go to BLANK (reload BLANK_CYCLES). `abort` high in IDLE blocks decisions.
- **BLANK.** Requests are ignored. Exit to IDLE; with BLANK_CYCLES = 0, go PULSE → IDLE.
- **Load sharing** is evaluated at decisions only:
  - Both requests high → `share_cnt`++ (saturates at LS_ENTER) and `solo_cnt` clears.
  - Otherwise → `solo_cnt`++ (saturates at LS_EXIT) and `share_cnt` clears.
  - `load_sharing_active` sets on the edge `share_cnt` reaches LS_ENTER and clears on the edge `solo_cnt` reaches LS_EXIT.
- **Invariant:** `gate_5v & gate_other` is never 1.

## Timing
- **Reset** (synchronous, any state, mid-pulse included), on the next edge:
  - state = IDLE;
  - `gate_5v` = `gate_other` = 0;
  - `busy` = 0;
  - `grant_id` = 1;
  - `load_sharing_active` = 0;
  - both counters = 0;
  - timer = 0.
- **Gate latency:** the gate is first high DEAD_CYCLES+1 clocks after the decision edge and stays high exactly PULSE_CYCLES clocks.
- **Pulse spacing:** minimum spacing between decisions is 1+DEAD+PULSE+BLANK clocks; 89 with defaults.
- **`busy`:** rises on the edge after the decision and falls on the edge entering IDLE.
- **Abort:** gates drop one clock after `abort` is sampled high.
- **Simultaneous abort and timer expiry in PULSE:** abort path wins, BLANK is entered, same result.
- **Requests during DEAD/PULSE/BLANK:** not queued; re-evaluated on the first IDLE edge.

## Structure
- Shared package/include `apsm_pkg`:
  - state encodings `ST_IDLE`, `ST_DEAD`, `ST_PULSE`, `ST_BLANK`;
  - rail IDs `RAIL_5V = 0`, `RAIL_OTHER = 1`.
  - The rail controllers reuse the rail IDs.
- Sub-module `apsm_phase_timer`: loadable `CNT_W` down-counter with a `load`/`value` input and a `done` output (value == 1).
- Arbitration logic and load-sharing counters stay in the top level.

## Test plan
- **Single request.** Reset, then `req_5v` = 1 from cycle 10. Required:
  - decision at 10;
  - `gate_5v` high cycles 19–82;
  - `busy` 11–98;
  - next `gate_5v` rise at cycle 108.
- **Contention / round-robin.** Both requests high continuously. Required:
  - grants alternate 5V, other, 5V…;
  - `load_sharing_active` rises at the 4th decision;
  - the gates never overlap.
- **Emergency priority.** Both requests high, `emerg_other` = 1 → other is granted even when round-robin favours other last; repeated every decision.
- **Abort.** `abort` pulsed at PULSE cycle 20. Required:
  - gate low next clock;
  - 16 BLANK cycles;
  - then a new decision if a request is still high.
- **Load-sharing exit.** After sharing is active, only `req_5v` is held for 8 decisions → flag clears at the 8th decision edge, not the 7th.
- **Reset mid-pulse.** `reset_in` asserted at PULSE cycle 30. Required:
  - all outputs at reset values next edge;
  - the first contended decision afterwards grants 5 V.
